// File: rtl/vga_stream_scaler_display.sv
// vga_stream_scaler_display: VGA timing generator that shows an Avalon-ST pixel stream, repeating pixels horizontally and reporting underflow.
module vga_stream_scaler_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CDEPTH = 8,
  parameter int ST_DATA_WIDTH = 3*CDEPTH,
  parameter int PIXEL_REPEAT = 1,
  parameter logic [3*CDEPTH-1:0] UNDERFLOW_RGB = '0,
  parameter int MM_CSR_START_ADDRESS = 0,
  parameter int MM_ADDR_WIDTH = 32,
  parameter int MM_DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     st_ready,
  input  logic [ST_DATA_WIDTH-1:0] st_data,
  input  logic                     st_startofpacket,
  input  logic                     st_endofpacket,
  input  logic                     st_valid,
  output logic                     mm_csr_write,
  output logic [MM_ADDR_WIDTH-1:0] mm_csr_address,
  output logic [MM_DATA_WIDTH-1:0] mm_csr_writedata,
  input  logic                     mm_csr_waitrequest,
  output logic                     vga_hs_out,
  output logic                     vga_vs_out,
  output logic                     vga_de,
  output logic [CDEPTH-1:0]        vga_r,
  output logic [CDEPTH-1:0]        vga_g,
  output logic [CDEPTH-1:0]        vga_b,
  output logic                     underflow,
  output logic [15:0]              underflow_frames
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [2:0] REP_MAX = 3'(PIXEL_REPEAT - 1);
  typedef enum logic [1:0] {OUT_OF_SYNC, RESTART_FRAME, WAIT_FOR_SOF, READ_FB} state_t;
  state_t state, state_n;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [2:0] rep;
  logic [ST_DATA_WIDTH-1:0] cache;
  logic [3*CDEPTH-1:0] pix, rgb_c;
  logic cache_valid, cache_eop;
  logic active, need, show_cache, take, restart_frame, uf_evt, hs_c, vs_c;
  assign active = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
  assign hs_c = (hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : !HS_POL;
  assign vs_c = (vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : !VS_POL;
  assign restart_frame = vcnt == VW'(V_ACTIVE + V_FP) && hcnt == '0;
  assign need = active && rep == 3'd0;
  assign show_cache = state == READ_FB && need && cache_valid;
  // Once the EOP pixel sits in the cache, stop pulling so the next frame's SOP stays in the stream.
  assign st_ready = state == WAIT_FOR_SOF ? !cache_valid : show_cache && !cache_eop;
  assign take = st_ready && st_valid;
  assign rgb_c = !active ? '0 : show_cache ? cache[3*CDEPTH-1:0] :
                 (state == READ_FB && rep != 3'd0) ? pix : UNDERFLOW_RGB;
  assign mm_csr_write = state == RESTART_FRAME;
  assign mm_csr_address = mm_csr_write ? MM_ADDR_WIDTH'(MM_CSR_START_ADDRESS) : '0;
  assign mm_csr_writedata = mm_csr_write ? MM_DATA_WIDTH'(1) : '0;
  always_comb begin
    state_n = state;
    case (state)
      RESTART_FRAME: if (!mm_csr_waitrequest) state_n = WAIT_FOR_SOF;
      WAIT_FOR_SOF: state_n = active ? OUT_OF_SYNC : (take && st_startofpacket) ? READ_FB : WAIT_FOR_SOF;
      READ_FB: if (need && !cache_valid) state_n = OUT_OF_SYNC;
      default: ;
    endcase
    uf_evt = state_n == OUT_OF_SYNC && state != OUT_OF_SYNC && !restart_frame;
    if (restart_frame) state_n = RESTART_FRAME;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
      rep <= '0;
      state <= OUT_OF_SYNC;
      cache <= '0;
      cache_valid <= 1'b0;
      cache_eop <= 1'b0;
      pix <= '0;
      underflow <= 1'b0;
      underflow_frames <= '0;
      vga_hs_out <= !HS_POL;
      vga_vs_out <= !VS_POL;
      vga_de <= 1'b0;
      {vga_b, vga_g, vga_r} <= '0;
    end else begin
      hcnt <= hcnt == HW'(H_TOTAL - 1) ? '0 : hcnt + 1'b1;
      if (hcnt == HW'(H_TOTAL - 1)) vcnt <= vcnt == VW'(V_TOTAL - 1) ? '0 : vcnt + 1'b1;
      rep <= (active && rep != REP_MAX) ? rep + 3'd1 : 3'd0;
      state <= state_n;
      if (state == RESTART_FRAME) cache_valid <= 1'b0;
      else if (show_cache) begin
        pix <= cache[3*CDEPTH-1:0];
        cache_valid <= 1'b0;
      end
      // Non-SOP words offered while waiting for a frame start are simply dropped.
      if (take && (state == READ_FB || st_startofpacket)) begin
        cache <= st_data;
        cache_eop <= st_endofpacket;
        cache_valid <= 1'b1;
      end
      if (uf_evt) begin
        underflow <= 1'b1;
        if (~&underflow_frames) underflow_frames <= underflow_frames + 16'd1;
      end
      vga_hs_out <= hs_c;
      vga_vs_out <= vs_c;
      vga_de <= active;
      {vga_b, vga_g, vga_r} <= rgb_c;
    end
  end
endmodule
